// File: rtl/wb_stage_if.sv
// MEM -> WB handshake bundle: valid/allowin plus the instruction fields
// that the write-back stage latches on acceptance.
interface wb_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ms_valid;
    logic                  ws_allowin;
    logic [31:0]           ms_pc;
    logic                  ms_gr_we;
    logic [ADDR_WIDTH-1:0] ms_dest;
    logic                  ms_res_from_mem;
    logic [2:0]            ms_load_op;
    logic [DATA_WIDTH-1:0] ms_alu_result;
    logic [DATA_WIDTH-1:0] ms_rt_old;

    // MEM stage side: offers an instruction, observes allowin
    modport master (
        output ms_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_load_op, ms_alu_result, ms_rt_old,
        input  ws_allowin
    );

    // WB stage side: accepts an instruction, reports allowin
    modport slave (
        input  ms_valid, ms_pc, ms_gr_we, ms_dest, ms_res_from_mem,
               ms_load_op, ms_alu_result, ms_rt_old,
        output ws_allowin
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM results, waits for load data, aligns and
// merges load data, drives the register-file write port, exports
// forwarding/stall information and counts retired instructions.
// Load alignment assumes a 32-bit datapath.
module wb_stage #(
    parameter int          DATA_WIDTH      = 32,
    parameter int          ADDR_WIDTH      = 5,
    // Value the retired-instruction counter takes on reset
    parameter logic [31:0] RETIRE_CNT_INIT = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    wb_stage_if.slave             ms,
    input  logic                  data_rvalid,
    input  logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  ws_fwd_valid,
    output logic                  ws_busy,
    output logic [ADDR_WIDTH-1:0] ws_fwd_dest,
    output logic [DATA_WIDTH-1:0] ws_fwd_data,
    output logic [31:0]           debug_wb_pc,
    output logic [3:0]            debug_wb_rf_wen,
    output logic [31:0]           retire_cnt
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LB  = 3'd1;
    localparam logic [2:0] OP_LBU = 3'd2;
    localparam logic [2:0] OP_LH  = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    // EMPTY: no instruction; WAIT: load without data yet; READY: result available
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                state_reg;
    logic [31:0]           pc_reg;
    logic                  gr_we_reg;
    logic [ADDR_WIDTH-1:0] dest_reg;
    logic                  res_from_mem_reg;
    logic [2:0]            load_op_reg;
    logic [DATA_WIDTH-1:0] alu_result_reg;
    logic [DATA_WIDTH-1:0] rt_old_reg;
    logic [DATA_WIDTH-1:0] rdata_buf_reg;
    logic                  rdata_buf_vld_reg;
    logic [31:0]           retire_cnt_reg;

    logic                  ws_valid;
    logic                  ready_go;
    logic                  allowin;
    logic                  advancing;
    logic                  retire;
    logic                  capture;
    logic                  writes_gpr;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] aligned;
    logic [3:0]            wen_mask;
    logic [1:0]            k;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign ws_valid   = (state_reg != EMPTY);
    // A load becomes ready the cycle its data arrives, or once it is buffered
    assign ready_go   = (state_reg == READY) | data_rvalid | rdata_buf_vld_reg;
    assign allowin    = ~ws_valid | ready_go;
    assign advancing  = ms.ms_valid & allowin;
    assign retire     = ws_valid & ready_go;
    assign capture    = data_rvalid & (state_reg == WAIT) & ~rdata_buf_vld_reg & ~advancing;
    assign writes_gpr = ws_valid & gr_we_reg & (dest_reg != '0);

    assign ms.ws_allowin = allowin;

    // Handshake, load-data buffering and retire counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= EMPTY;
            pc_reg            <= '0;
            gr_we_reg         <= 1'b0;
            dest_reg          <= '0;
            res_from_mem_reg  <= 1'b0;
            load_op_reg       <= '0;
            alu_result_reg    <= '0;
            rt_old_reg        <= '0;
            rdata_buf_reg     <= '0;
            rdata_buf_vld_reg <= 1'b0;
            retire_cnt_reg    <= RETIRE_CNT_INIT;
        end else begin
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
            if (capture) begin
                rdata_buf_reg     <= data_rdata;
                rdata_buf_vld_reg <= 1'b1;
            end
            if (advancing) begin
                pc_reg            <= ms.ms_pc;
                gr_we_reg         <= ms.ms_gr_we;
                dest_reg          <= ms.ms_dest;
                res_from_mem_reg  <= ms.ms_res_from_mem;
                load_op_reg       <= ms.ms_load_op;
                alu_result_reg    <= ms.ms_alu_result;
                rt_old_reg        <= ms.ms_rt_old;
                rdata_buf_vld_reg <= 1'b0;
                state_reg         <= ms.ms_res_from_mem ? WAIT : READY;
            end else if (allowin) begin
                state_reg <= EMPTY;
            end else if (capture) begin
                state_reg <= READY;
            end
        end
    end

    // Select load data and extract the addressed byte/halfword
    always_comb begin
        load_data = rdata_buf_vld_reg ? rdata_buf_reg : data_rdata;
        k         = alu_result_reg[1:0];
        case (k)
            2'd0:    byte_sel = load_data[7:0];
            2'd1:    byte_sel = load_data[15:8];
            2'd2:    byte_sel = load_data[23:16];
            default: byte_sel = load_data[31:24];
        endcase
        half_sel = k[1] ? load_data[31:16] : load_data[15:0];
    end

    // Align/merge load data and build the byte-write mask
    always_comb begin
        aligned  = load_data;
        wen_mask = 4'b1111;
        case (load_op_reg)
            OP_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  aligned = {24'h0, byte_sel};
            OP_LH:   aligned = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  aligned = {16'h0, half_sel};
            OP_LWL: begin
                case (k)
                    2'd0: begin
                        aligned  = {load_data[7:0], rt_old_reg[23:0]};
                        wen_mask = 4'b1000;
                    end
                    2'd1: begin
                        aligned  = {load_data[15:0], rt_old_reg[15:0]};
                        wen_mask = 4'b1100;
                    end
                    2'd2: begin
                        aligned  = {load_data[23:0], rt_old_reg[7:0]};
                        wen_mask = 4'b1110;
                    end
                    default: begin
                        aligned  = load_data;
                        wen_mask = 4'b1111;
                    end
                endcase
            end
            OP_LWR: begin
                case (k)
                    2'd0: begin
                        aligned  = load_data;
                        wen_mask = 4'b1111;
                    end
                    2'd1: begin
                        aligned  = {rt_old_reg[31:24], load_data[31:8]};
                        wen_mask = 4'b0111;
                    end
                    2'd2: begin
                        aligned  = {rt_old_reg[31:16], load_data[31:16]};
                        wen_mask = 4'b0011;
                    end
                    default: begin
                        aligned  = {rt_old_reg[31:8], load_data[31:24]};
                        wen_mask = 4'b0001;
                    end
                endcase
            end
            default: aligned = load_data;   // LW and the unused encoding 7
        endcase
        if (!res_from_mem_reg) begin
            wen_mask = 4'b1111;
        end
    end

    // Register-file write port, forwarding and debug outputs
    always_comb begin
        rf_we           = retire & gr_we_reg & (dest_reg != '0);
        rf_waddr        = dest_reg;
        rf_wdata        = res_from_mem_reg ? aligned : alu_result_reg;
        ws_fwd_valid    = writes_gpr & ready_go;
        ws_busy         = writes_gpr & ~ready_go;
        ws_fwd_dest     = dest_reg;
        ws_fwd_data     = rf_wdata;
        debug_wb_pc     = pc_reg;
        debug_wb_rf_wen = {4{rf_we}} & wen_mask;
        retire_cnt      = retire_cnt_reg;
    end

endmodule
